// File: rtl/hazard_sequencer.sv
// Pipeline control for the 5-stage RV32I core: branch/jump redirect, load-use
// bubbles, data-memory freeze, post-reset boot flush and stall/flush counters.
module hazard_sequencer #(
    parameter int unsigned BOOT_CYCLES = 2,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      inst_execute,
    input  logic             BrEq,
    input  logic             BrLT,
    input  logic             ex_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             mem_is_ls,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             pc_sel,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_MWAIT} state_e;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [3:0] BOOT_INIT = 4'(BOOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [3:0]       boot_q, boot_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic       taken, redirect, luse, memwait;
    logic       stall_inc, flush_inc;
    logic       unused_bits;

    assign opcode      = inst_execute[6:0];
    assign funct3      = inst_execute[14:12];
    assign rd          = inst_execute[11:7];
    assign unused_bits = ^inst_execute[31:15];

    always_comb begin
        taken = 1'b0;
        if (opcode == OP_BRANCH) begin
            case (funct3)
                3'b000:  taken = BrEq;
                3'b001:  taken = !BrEq;
                3'b100:  taken = BrLT;
                3'b101:  taken = !BrLT;
                3'b110:  taken = BrLT;
                3'b111:  taken = !BrLT;
                default: taken = 1'b0;
            endcase
        end else if (opcode == OP_JAL || opcode == OP_JALR) begin
            taken = 1'b1;
        end
    end

    assign redirect = ex_valid && taken;
    assign luse     = ex_valid && (opcode == OP_LOAD) && (rd != 5'd0) &&
                      ((id_uses_rs1 && rd == id_rs1) || (id_uses_rs2 && rd == id_rs2));
    assign memwait  = mem_is_ls && !dmem_ready;

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        state_d     = state_q;
        boot_d      = boot_q;
        pc_en       = 1'b1;
        pc_sel      = 1'b0;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b0;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        case (state_q)
            ST_BOOT: begin
                pc_en       = 1'b0;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                if (boot_q == 4'd0) state_d = ST_RUN;
                else                boot_d  = boot_q - 4'd1;
            end
            ST_RUN, ST_MWAIT: begin
                // A MWAIT cycle whose memory completes is handled exactly like RUN.
                if (memwait) begin
                    pc_en     = 1'b0;
                    if_id_en  = 1'b0;
                    id_ex_en  = 1'b0;
                    ex_mem_en = 1'b0;
                    mem_wb_en = 1'b0;
                    stall_inc = 1'b1;
                    state_d   = ST_MWAIT;
                end else begin
                    state_d = ST_RUN;
                    if (redirect) begin
                        pc_sel      = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        flush_inc   = 1'b1;
                    end else if (luse) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                        stall_inc   = 1'b1;
                    end
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (stall_inc && stall_q != '1) stall_d = stall_q + CNT_ONE;
        if (flush_inc && flush_q != '1) flush_d = flush_q + CNT_ONE;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            boot_q  <= BOOT_INIT;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            boot_q  <= boot_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench: directed scenarios then random traffic, compared each
// cycle against a mode/counter reference model of the pipeline controller.
module tb_hazard_sequencer;

    localparam int BOOT = 2;
    localparam int CW   = 5;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic [31:0] inst;
        logic        breq;
        logic        brlt;
        logic        exv;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic        ls;
        logic        rdy;
    } stim_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   inst_execute = '0;
    logic          BrEq = 1'b0, BrLT = 1'b0, ex_valid = 1'b0;
    logic [4:0]    id_rs1 = '0, id_rs2 = '0;
    logic          id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
    logic          mem_is_ls = 1'b0, dmem_ready = 1'b1;
    logic          pc_en, pc_sel, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int  errors = 0;
    int  checks = 0;
    int  boot_left = 0;
    int  m_stall = 0;
    int  m_flush = 0;
    bit  m_valid = 1'b0;

    hazard_sequencer #(.BOOT_CYCLES(BOOT), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .inst_execute(inst_execute),
        .BrEq(BrEq), .BrLT(BrLT), .ex_valid(ex_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .mem_is_ls(mem_is_ls), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .pc_sel(pc_sel), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd);
        logic [16:0] hi;
        hi = 17'($urandom());
        return {hi, f3, rd, op};
    endfunction

    function automatic stim_t nop();
        stim_t s;
        s      = '0;
        s.inst = enc(7'b0010011, 3'b000, 5'd1);
        s.exv  = 1'b1;
        s.rdy  = 1'b1;
        return s;
    endfunction

    // One clock: apply stimulus, check outputs mid-cycle, then advance the model.
    task automatic cycle(input logic rst, input stim_t s);
        logic [6:0] op;
        logic [2:0] f3;
        logic [4:0] rd;
        bit         tk, redir, luse, mw, in_run;
        logic [7:0] exp_ctl;
        @(posedge clk);
        #1;
        rst_n = rst;       inst_execute = s.inst;
        BrEq = s.breq;     BrLT = s.brlt;      ex_valid = s.exv;
        id_rs1 = s.rs1;    id_rs2 = s.rs2;
        id_uses_rs1 = s.u1; id_uses_rs2 = s.u2;
        mem_is_ls = s.ls;  dmem_ready = s.rdy;
        #2;
        op = s.inst[6:0];
        f3 = s.inst[14:12];
        rd = s.inst[11:7];
        tk = 1'b0;
        if (op == 7'b1100011)
            tk = (f3 == 3'b000) ? s.breq :
                 (f3 == 3'b001) ? !s.breq :
                 (f3 == 3'b100 || f3 == 3'b110) ? s.brlt :
                 (f3 == 3'b101 || f3 == 3'b111) ? !s.brlt : 1'b0;
        else if (op == 7'b1101111 || op == 7'b1100111)
            tk = 1'b1;
        redir  = s.exv && tk;
        luse   = s.exv && op == 7'b0000011 && rd != 0 &&
                 ((s.u1 && rd == s.rs1) || (s.u2 && rd == s.rs2));
        mw     = s.ls && !s.rdy;
        in_run = (boot_left == 0);
        // {pc_en, pc_sel, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en}
        if (!in_run)    exp_ctl = 8'b0011_1111;
        else if (mw)    exp_ctl = 8'b0000_0000;
        else if (redir) exp_ctl = 8'b1111_1111;
        else if (luse)  exp_ctl = 8'b0000_1111;
        else            exp_ctl = 8'b1010_1011;
        if (m_valid) begin
            check("ctl", 32'({pc_en, pc_sel, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en}), 32'(exp_ctl));
            check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
            check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
        end
        if (!rst) begin
            boot_left = BOOT;
            m_stall   = 0;
            m_flush   = 0;
            m_valid   = 1'b1;
        end else if (m_valid) begin
            if (!in_run) boot_left--;
            else begin
                if ((mw || (luse && !redir)) && m_stall < CMAX) m_stall++;
                if (redir && !mw && m_flush < CMAX) m_flush++;
            end
        end
    endtask

    initial begin
        stim_t s;
        // Reset held three cycles, then the boot flush.
        for (int i = 0; i < 3; i++) cycle(1'b0, nop());
        for (int i = 0; i < BOOT + 1; i++) cycle(1'b1, nop());

        // Branch resolution.
        s = nop(); s.inst = enc(7'b1100011, 3'b000, 5'd3); s.breq = 1'b1; cycle(1'b1, s);
        s.breq = 1'b0; cycle(1'b1, s);
        s = nop(); s.inst = enc(7'b1100011, 3'b111, 5'd3); s.brlt = 1'b0; cycle(1'b1, s);
        s = nop(); s.inst = enc(7'b1100011, 3'b010, 5'd3); s.breq = 1'b1; s.brlt = 1'b1; cycle(1'b1, s);

        // Load-use, then the rd=x0 and unused-source cases.
        s = nop(); s.inst = enc(7'b0000011, 3'b010, 5'd5); s.rs2 = 5'd5; s.u2 = 1'b1; cycle(1'b1, s);
        s.inst = enc(7'b0000011, 3'b010, 5'd0); s.rs2 = 5'd0; cycle(1'b1, s);
        s.inst = enc(7'b0000011, 3'b010, 5'd5); s.rs2 = 5'd5; s.u2 = 1'b0; cycle(1'b1, s);

        // Memory freeze with JAL in EX, then release with the redirect.
        s = nop(); s.inst = enc(7'b1101111, 3'b000, 5'd1); s.ls = 1'b1; s.rdy = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b1, s);
        s.rdy = 1'b1; cycle(1'b1, s);

        // JALR in a bubble slot.
        s = nop(); s.inst = enc(7'b1100111, 3'b000, 5'd1); s.exv = 1'b0; cycle(1'b1, s);

        // Reset during a memory wait, boot sequence repeats.
        s = nop(); s.ls = 1'b1; s.rdy = 1'b0;
        cycle(1'b1, s); cycle(1'b1, s);
        cycle(1'b0, s);
        for (int i = 0; i < BOOT + 2; i++) cycle(1'b1, nop());

        // Random traffic with small register indices to provoke hazards.
        for (int i = 0; i < 1500; i++) begin
            s = nop();
            case ($urandom_range(0, 5))
                0, 1:    s.inst = enc(7'b1100011, 3'($urandom()), 5'($urandom_range(0, 3)));
                2:       s.inst = enc(7'b1101111, 3'($urandom()), 5'($urandom_range(0, 3)));
                3:       s.inst = enc(7'b1100111, 3'($urandom()), 5'($urandom_range(0, 3)));
                4:       s.inst = enc(7'b0000011, 3'($urandom()), 5'($urandom_range(0, 3)));
                default: s.inst = enc(7'($urandom()), 3'($urandom()), 5'($urandom_range(0, 3)));
            endcase
            s.breq = 1'($urandom());
            s.brlt = 1'($urandom());
            s.exv  = ($urandom_range(0, 3) != 0);
            s.rs1  = 5'($urandom_range(0, 3));
            s.rs2  = 5'($urandom_range(0, 3));
            s.u1   = 1'($urandom());
            s.u2   = 1'($urandom());
            s.ls   = ($urandom_range(0, 2) == 0);
            s.rdy  = ($urandom_range(0, 2) != 0);
            cycle(($urandom_range(0, 63) != 0), s);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
